// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and a
// response classifier.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        DONE
    } axi_lite_state_e;

    // SLVERR and DECERR are reported to the core as a single error bit.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:  return 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns a single-outstanding core load/store request
// into one AXI4-Lite transaction and returns a one-cycle response pulse.
module axi_lite_master
    import axi_pkg::*;
#(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [AXI_AWIDTH-1:0]   req_addr,
    input  logic [AXI_DWIDTH-1:0]   req_wdata,
    input  logic [AXI_DWIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [AXI_DWIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
    output logic                    AXI_AWVALID,
    input  logic                    AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
    output logic                    AXI_WVALID,
    input  logic                    AXI_WREADY,
    input  logic [1:0]              AXI_BRESP,
    input  logic                    AXI_BVALID,
    output logic                    AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
    output logic                    AXI_ARVALID,
    input  logic                    AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]              AXI_RRESP,
    input  logic                    AXI_RVALID,
    output logic                    AXI_RREADY
);

    axi_lite_state_e state, state_nx;

    logic                    aw_done, w_done, ar_done;
    logic [AXI_AWIDTH-1:0]   addr_q;
    logic [AXI_DWIDTH-1:0]   wdata_q;
    logic [AXI_DWIDTH/8-1:0] wstrb_q;
    logic                    cap_b, cap_r;

    assign AXI_AWADDR = addr_q;
    assign AXI_ARADDR = addr_q;
    assign AXI_WDATA  = wdata_q;
    assign AXI_WSTRB  = wstrb_q;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        AXI_AWVALID = 1'b0;
        AXI_WVALID  = 1'b0;
        AXI_BREADY  = 1'b0;
        AXI_ARVALID = 1'b0;
        AXI_RREADY  = 1'b0;
        cap_b       = 1'b0;
        cap_r       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_we ? WRITE : READ;
            end
            WRITE: begin
                AXI_AWVALID = !aw_done;
                AXI_WVALID  = !w_done;
                AXI_BREADY  = 1'b1;
                // A B response arriving with the last AW/W handshake is taken at once.
                if ((aw_done || AXI_AWREADY) && (w_done || AXI_WREADY)) begin
                    cap_b    = AXI_BVALID;
                    state_nx = AXI_BVALID ? DONE : WRESP;
                end
            end
            WRESP: begin
                AXI_BREADY = 1'b1;
                cap_b      = AXI_BVALID;
                if (AXI_BVALID) state_nx = DONE;
            end
            READ: begin
                AXI_ARVALID = !ar_done;
                AXI_RREADY  = 1'b1;
                cap_r       = AXI_RVALID;
                if (AXI_RVALID) state_nx = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ar_done   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                ar_done <= 1'b0;
            end
            if (AXI_AWVALID && AXI_AWREADY) aw_done <= 1'b1;
            if (AXI_WVALID && AXI_WREADY)   w_done  <= 1'b1;
            if (AXI_ARVALID && AXI_ARREADY) ar_done <= 1'b1;
            if (cap_b) begin
                rsp_rdata <= '0;
                rsp_err   <= resp_is_err(AXI_BRESP);
            end
            if (cap_r) begin
                rsp_rdata <= AXI_RDATA;
                rsp_err   <= resp_is_err(AXI_RRESP);
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-configurable AXI4-Lite responder with a
// small word memory, a vector table, directed stall/reset sequences and a
// randomized run checked against a reference memory and latency rule.
module tb_axi_lite_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axi_lite_master dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Responder configuration: each delay is the cycle offset, counted from
    // the first VALID cycle, at which the responder drives its READY/VALID.
    int         aw_d = 1, w_d = 1, b_d = 1, ar_d = 1, r_d = 1;
    logic [1:0] cfg_resp = 2'b00;
    logic [31:0] mem [16];
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    int          viol = 0;

    initial begin
        logic busy, wr, p_aw, p_w, p_ar;
        int t;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        busy = 0; wr = 0; t = 0; p_aw = 0; p_w = 0; p_ar = 0;
        cap_addr = 0; cap_wdata = 0; cap_wstrb = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                busy = 0; p_aw = 0; p_w = 0; p_ar = 0;
            end else begin
                // VALID must not drop before its handshake; RREADY must accompany ARVALID.
                if (p_aw && !awready && !awvalid) viol++;
                if (p_w && !wready && !wvalid) viol++;
                if (p_ar && !arready && !arvalid) viol++;
                if (arvalid && !rready) viol++;
                p_aw = awvalid; p_w = wvalid; p_ar = arvalid;
                awready = 0; wready = 0; arready = 0;
                if (bvalid) begin bvalid = 0; busy = 0; end
                if (rvalid) begin rvalid = 0; busy = 0; end
                if (!busy && (awvalid || wvalid || arvalid)) begin
                    busy = 1; t = 0; wr = awvalid || wvalid;
                end
                if (busy) begin
                    t++;
                    if (wr) begin
                        if (t == aw_d + 1) begin awready = 1; cap_addr = awaddr; end
                        if (t == w_d + 1) begin wready = 1; cap_wdata = wdata; cap_wstrb = wstrb; end
                        if (t == b_d + 1) begin
                            bvalid = 1; bresp = cfg_resp;
                            for (int b = 0; b < 4; b++)
                                if (cap_wstrb[b]) mem[cap_addr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                        end
                    end else begin
                        if (t == ar_d + 1) begin arready = 1; cap_addr = araddr; end
                        if (t == r_d + 1) begin
                            rvalid = 1; rresp = cfg_resp; rdata = mem[cap_addr[5:2]];
                        end
                    end
                end
            end
        end
    end

    // Reference memory: whole-word merge under a byte mask.
    logic [31:0] ref_mem [16];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return (old & ~m) | (d & m);
    endfunction

    logic tr_aw [32], tr_w [32], tr_ar [32], tr_rr [32], tr_rdy [32];

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic er,
                          output int lat);
        int k;
        rd = 32'h0; er = 1'b0; lat = 0;
        for (int i = 0; i < 32; i++) begin
            tr_aw[i] = 0; tr_w[i] = 0; tr_ar[i] = 0; tr_rr[i] = 0; tr_rdy[i] = 0;
        end
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            if (lat <= 32) begin
                tr_aw[lat-1] = awvalid; tr_w[lat-1] = wvalid; tr_ar[lat-1] = arvalid;
                tr_rr[lat-1] = rready;  tr_rdy[lat-1] = req_ready;
            end
            @(negedge clk);
            lat++;
        end
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    // One cycle after the pulse: pulse gone, ready again, result held.
    task automatic post(input string n, input logic [31:0] exp_rd, input logic exp_er);
        @(negedge clk);
        chk({n, "_pulse_len"}, 32'(rsp_valid), 32'd0);
        chk({n, "_ready_next"}, 32'(req_ready), 32'd1);
        chk({n, "_rdata_hold"}, rsp_rdata, exp_rd);
        chk({n, "_err_hold"}, 32'(rsp_err), 32'(exp_er));
    endtask

    function automatic logic any_rdy(input int lat);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 32; i++) if (i < lat) r = r | tr_rdy[i];
        return r;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt [10];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, seen;
        int          lat, exp_lat;
        string       n;

        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd, a, d;
        logic        er, exp_er, seen, we;
        logic [3:0]  s;
        int          lat, exp_lat;
        string       n;

        vt[0] = '{1'b1, 32'h8,  32'hCAFEBABE, 4'hF, 2'b00, 32'h00000000, 1'b0, 3};
        vt[1] = '{1'b0, 32'h8,  32'h0,        4'h0, 2'b00, 32'hCAFEBABE, 1'b0, 3};
        vt[2] = '{1'b1, 32'h8,  32'h11223344, 4'hF, 2'b00, 32'h00000000, 1'b0, 3};
        vt[3] = '{1'b1, 32'h8,  32'h000000AA, 4'h1, 2'b00, 32'h00000000, 1'b0, 3};
        vt[4] = '{1'b0, 32'h8,  32'h0,        4'h0, 2'b00, 32'h112233AA, 1'b0, 3};
        vt[5] = '{1'b1, 32'hC,  32'hDEADBEEF, 4'hC, 2'b00, 32'h00000000, 1'b0, 3};
        vt[6] = '{1'b0, 32'hC,  32'h0,        4'hF, 2'b00, 32'hDEAD0000, 1'b0, 3};
        vt[7] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b11, 32'h00000000, 1'b1, 3};
        vt[8] = '{1'b1, 32'h14, 32'h01020304, 4'hF, 2'b01, 32'h00000000, 1'b0, 3};
        vt[9] = '{1'b0, 32'h14, 32'h0,        4'h0, 2'b10, 32'h01020304, 1'b1, 3};
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 0; req_wdata = 0; req_wstrb = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_regs", awaddr | araddr | wdata | 32'(wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table against the zero-wait memory responder.
        for (int i = 0; i < 10; i++) begin
            n = $sformatf("vec%0d", i);
            cfg_resp = vt[i].resp;
            do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, lat);
            chk({n, "_rdata"}, rd, vt[i].exp_rdata);
            chk({n, "_err"}, 32'(er), 32'(vt[i].exp_err));
            chk({n, "_lat"}, 32'(lat), 32'(vt[i].exp_lat));
            chk({n, "_addr"}, cap_addr, vt[i].addr);
            if (!vt[i].we) chk({n, "_ar_rready"}, 32'(tr_ar[0] & tr_rr[0]), 32'd1);
            if (vt[i].we)
                ref_mem[vt[i].addr[5:2]] = merge(ref_mem[vt[i].addr[5:2]], vt[i].wdata, vt[i].strb);
            post(n, vt[i].exp_rdata, vt[i].exp_err);
        end

        // Stalled write: AWREADY +1, WREADY +4, BVALID +6 with SLVERR.
        aw_d = 1; w_d = 4; b_d = 6; cfg_resp = 2'b10;
        do_req(1'b1, 32'h20, 32'h55AA55AA, 4'hF, rd, er, lat);
        chk("bfmw_lat", 32'(lat), 32'd8);
        chk("bfmw_err", 32'(er), 32'd1);
        chk("bfmw_aw_hold", 32'(tr_aw[0] & tr_aw[1]), 32'd1);
        chk("bfmw_aw_drop", 32'(tr_aw[2]), 32'd0);
        chk("bfmw_w_hold", 32'(tr_w[0] & tr_w[4]), 32'd1);
        chk("bfmw_w_drop", 32'(tr_w[5]), 32'd0);
        chk("bfmw_busy", 32'(any_rdy(lat)), 32'd0);
        ref_mem[8] = merge(ref_mem[8], 32'h55AA55AA, 4'hF);
        post("bfmw", 32'h0, 1'b1);

        // Stalled read: RVALID five cycles after ARREADY.
        aw_d = 1; w_d = 1; b_d = 1; cfg_resp = 2'b00;
        do_req(1'b1, 32'h24, 32'h12345678, 4'hF, rd, er, lat);
        ref_mem[9] = 32'h12345678;
        post("preload", 32'h0, 1'b0);
        ar_d = 1; r_d = 6;
        do_req(1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
        chk("bfmr_lat", 32'(lat), 32'd8);
        chk("bfmr_rdata", rd, 32'h12345678);
        chk("bfmr_err", 32'(er), 32'd0);
        chk("bfmr_ar_hold", 32'(tr_ar[0] & tr_ar[1] & tr_rr[0]), 32'd1);
        chk("bfmr_ar_drop", 32'(tr_ar[2]), 32'd0);
        chk("bfmr_busy", 32'(any_rdy(lat)), 32'd0);
        post("bfmr", 32'h12345678, 1'b0);

        // Reset while the write still waits for WREADY.
        aw_d = 1; w_d = 4; b_d = 6; ar_d = 1; r_d = 1;
        req_we = 1'b1; req_addr = 32'h28; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstw_pre", {30'd0, awvalid, wvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        chk("rstw_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen = seen | rsp_valid; end
        chk("rstw_no_rsp", 32'(seen), 32'd0);
        chk("rstw_ready", 32'(req_ready), 32'd1);
        aw_d = 1; w_d = 1; b_d = 1;
        do_req(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        chk("rstw_recover", rd, 32'h112233AA);
        post("rstw", 32'h112233AA, 1'b0);

        // Randomized traffic against the reference memory and latency rule.
        for (int i = 0; i < 40; i++) begin
            n = $sformatf("rnd%0d", i);
            we = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) << 2;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            cfg_resp = 2'($urandom_range(0, 3));
            aw_d = $urandom_range(1, 4);
            w_d  = $urandom_range(1, 4);
            b_d  = ((aw_d > w_d) ? aw_d : w_d) + $urandom_range(0, 3);
            ar_d = $urandom_range(1, 4);
            r_d  = ar_d + $urandom_range(0, 4);
            exp_rd  = we ? 32'h0 : ref_mem[a[5:2]];
            exp_er  = cfg_resp[1];
            exp_lat = (we ? b_d : r_d) + 2;
            do_req(we, a, d, s, rd, er, lat);
            chk({n, "_rdata"}, rd, exp_rd);
            chk({n, "_err"}, 32'(er), 32'(exp_er));
            chk({n, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({n, "_addr"}, cap_addr, a);
            if (we) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
            post(n, exp_rd, exp_er);
        end

        for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);
        chk("protocol", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
